predecode: RTL and testbench

- Pre-decode stage (pD) between Fetch and Decode.
- Accepts fetched instructions, buffers them in a small in-order queue, and statically predicts direct branches at the queue head.
- Drives `predict_BUS` back to Fetch to redirect the PC.
- Forwards instruction, PC, prediction and exception fields to Decode on a valid/allowin handshake.

---
 rtl/predecode_pkg.sv | 38 +++
 rtl/predecode_branch.sv | 46 ++++
 rtl/predecode.sv | 139 +++++++++++++
 tb/tb_predecode.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/predecode_pkg.sv
// predecode_pkg: shared widths, opcode constants and the queue entry layout
// for the pre-decode stage.
//
// Contents:
//   FPD_BUS_WID / PDD_BUS_WID / PREDICT_BUS_WID  bus widths (75 / 107 / 33)
//   OP_*                                         inst[31:26] major opcodes
//   pd_entry_t                                   one queue entry; its bit
//                                                layout is exactly pDD_BUS
//
// Configuration macro: PREDECODE_BTFN_EN (consumed by predecode_branch).
package predecode_pkg;

  localparam int FPD_BUS_WID     = 75;
  localparam int PDD_BUS_WID     = 107;
  localparam int PREDICT_BUS_WID = 33;

  localparam logic [5:0] OP_JIRL = 6'b010011;
  localparam logic [5:0] OP_B    = 6'b010100;
  localparam logic [5:0] OP_BL   = 6'b010101;
  localparam logic [5:0] OP_BEQ  = 6'b010110;
  localparam logic [5:0] OP_BNE  = 6'b010111;
  localparam logic [5:0] OP_BLT  = 6'b011000;
  localparam logic [5:0] OP_BGE  = 6'b011001;
  localparam logic [5:0] OP_BLTU = 6'b011010;
  localparam logic [5:0] OP_BGEU = 6'b011011;

  // Field order matches pDD_BUS so the head entry drives the bus directly.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex;
    logic [7:0]  ecode;
    logic        esubcode;
  } pd_entry_t;

endpackage

// File: rtl/predecode_branch.sv
// predecode_branch: combinational static predictor for direct branches.
// Reusable by Decode to re-derive the prediction for verification.
//
// Ports:
//   inst       in  32  instruction word
//   pc         in  32  instruction address
//   is_br      out  1  B, BL or a conditional branch (JIRL excluded)
//   pred_taken out  1  static prediction (ex gating is the caller's job)
//   target     out 32  pc + sign-extended word offset, modulo 2^32
//
// Configuration macro: PREDECODE_BTFN_EN -- when defined, backward
// conditional branches are predicted taken; otherwise only B/BL are.
module predecode_branch
  import predecode_pkg::*;
(
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  output logic        is_br,
  output logic        pred_taken,
  output logic [31:0] target
);

  logic [5:0]  op;
  logic [25:0] offs26;
  logic [15:0] offs16;
  logic        is_b;
  logic        is_cond;

  assign op      = inst[31:26];
  assign offs26  = {inst[9:0], inst[25:10]};
  assign offs16  = inst[25:10];
  assign is_b    = (op == OP_B) || (op == OP_BL);
  assign is_cond = (op >= OP_BEQ) && (op <= OP_BGEU);
  assign is_br   = is_b | is_cond;

  // Offsets are in words; wrap past 2^32 is intended.
  assign target = pc + (is_b ? {{4{offs26[25]}}, offs26, 2'b00}
                             : {{14{offs16[15]}}, offs16, 2'b00});

`ifdef PREDECODE_BTFN_EN
  assign pred_taken = is_b | (is_cond & offs16[15]);
`else
  assign pred_taken = is_b;
`endif

endmodule

// File: rtl/predecode.sv
// predecode: pre-decode stage between Fetch and Decode. Buffers fetched
// instructions in an in-order circular queue, statically predicts direct
// branches at the queue head and redirects Fetch through predict_BUS.
//
// Ports:
//   clk, rstn     clock, synchronous active-low reset
//   FpD_valid     in   Fetch presents an instruction
//   FpD_BUS       in   {pc, inst, pc_en (unused), ex, ecode, esubcode}
//   pD_allowin    out  queue can take an instruction this cycle
//   predict_BUS   out  {predict_taken, predict_target}, one-cycle pulse
//   br_taken_D/E, ex_en, ertn_flush  in  flush sources
//   D_allowin     in   Decode accepts
//   pDD_valid     out  head entry offered to Decode
//   pDD_BUS       out  {pc, inst, pred_taken, pred_target, ex, ecode, esubcode}
//
// Handshake: a transfer happens on a clock edge where the producer's valid
// and the consumer's allowin are both 1; valid never depends on allowin.
//
// Configuration macro: PREDECODE_BTFN_EN (see predecode_branch).
module predecode
  import predecode_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int FPD_W = FPD_BUS_WID,
  parameter int PDD_W = PDD_BUS_WID
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       FpD_valid,
  input  logic [FPD_W-1:0]           FpD_BUS,
  output logic                       pD_allowin,
  output logic [PREDICT_BUS_WID-1:0] predict_BUS,
  input  logic                       br_taken_D,
  input  logic                       br_taken_E,
  input  logic                       ex_en,
  input  logic                       ertn_flush,
  input  logic                       D_allowin,
  output logic                       pDD_valid,
  output logic [PDD_W-1:0]           pDD_BUS
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  pd_entry_t        q [DEPTH];
  logic [DEPTH-1:0] q_valid;
  logic [DEPTH-1:0] q_eval;   // head has been through its prediction cycle
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic        flush;
  logic        do_eval;
  logic        do_predict;
  logic        do_pop;
  logic        do_push;
  logic        br_is;
  logic        br_taken;
  logic [31:0] br_target;
  logic        pc_en_unused;

  assign pc_en_unused = FpD_BUS[10];

  predecode_branch u_branch (
    .inst       (q[head].inst),
    .pc         (q[head].pc),
    .is_br      (br_is),
    .pred_taken (br_taken),
    .target     (br_target)
  );

  assign flush      = br_taken_D | br_taken_E | ex_en | ertn_flush;
  assign do_eval    = q_valid[head] & ~q_eval[head] & ~flush;
  assign do_predict = do_eval & br_is & br_taken & ~q[head].ex;
  assign pDD_valid  = q_valid[head] & q_eval[head] & ~flush;
  assign do_pop     = pDD_valid & D_allowin;
  assign pD_allowin = (count < CNT_W'(DEPTH)) |
                      ((count == CNT_W'(DEPTH)) & do_pop);
  // A push in a prediction cycle would be wrong-path; Fetch already holds
  // FpD_valid low then, this just keeps the queue consistent if it doesn't.
  assign do_push    = FpD_valid & pD_allowin & ~flush & ~do_predict;

  assign predict_BUS = {do_predict, do_predict ? br_target : 32'h0};
  assign pDD_BUS     = q[head];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      q_valid <= '0;
      q_eval  <= '0;
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else if (flush) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      q_valid <= '0;
      q_eval  <= '0;
    end else begin
      if (do_pop) begin
        q_valid[head] <= 1'b0;
        head          <= head + PTR_W'(1);
      end
      if (do_predict) begin
        q_eval[head]         <= 1'b1;
        q[head].pred_taken   <= 1'b1;
        q[head].pred_target  <= br_target;
        // Everything behind a taken branch was fetched down the wrong path.
        for (int i = 0; i < DEPTH; i++)
          if (PTR_W'(i) != head) q_valid[i] <= 1'b0;
        tail  <= head + PTR_W'(1);
        count <= CNT_W'(1);
      end else begin
        if (do_eval) begin
          q_eval[head]        <= 1'b1;
          q[head].pred_taken  <= 1'b0;
          q[head].pred_target <= 32'h0;
        end
        count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
      // Placed after the pop so a full-queue pop+push on the same slot keeps
      // the new entry valid.
      if (do_push) begin
        q[tail].pc          <= FpD_BUS[74:43];
        q[tail].inst        <= FpD_BUS[42:11];
        q[tail].ex          <= FpD_BUS[9];
        q[tail].ecode       <= FpD_BUS[8:1];
        q[tail].esubcode    <= FpD_BUS[0];
        q[tail].pred_taken  <= 1'b0;
        q[tail].pred_target <= 32'h0;
        q_valid[tail]       <= 1'b1;
        q_eval[tail]        <= 1'b0;
        tail                <= tail + PTR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_predecode.sv
module tb_predecode;

  localparam int DEPTH = 2;
  localparam int W     = 107;
  localparam logic [31:0] NOP  = 32'h02800000;
  localparam logic [31:0] BINS = 32'h50004000;
  localparam logic [31:0] BEQI = 32'h5BFFF000;

  logic         clk = 1'b0;
  logic         rstn;
  logic         FpD_valid;
  logic [74:0]  FpD_BUS;
  logic         pD_allowin;
  logic [32:0]  predict_BUS;
  logic         br_taken_D, br_taken_E, ex_en, ertn_flush;
  logic         D_allowin;
  logic         pDD_valid;
  logic [106:0] pDD_BUS;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  predecode #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .FpD_valid   (FpD_valid),
    .FpD_BUS     (FpD_BUS),
    .pD_allowin  (pD_allowin),
    .predict_BUS (predict_BUS),
    .br_taken_D  (br_taken_D),
    .br_taken_E  (br_taken_E),
    .ex_en       (ex_en),
    .ertn_flush  (ertn_flush),
    .D_allowin   (D_allowin),
    .pDD_valid   (pDD_valid),
    .pDD_BUS     (pDD_BUS)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Signed byte offset of a direct branch, straight from the ISA encoding.
  function automatic longint ref_offset(input logic [31:0] inst);
    longint off;
    if (inst[31:26] == 6'd20 || inst[31:26] == 6'd21) begin
      off = longint'({inst[9:0], inst[25:10]});
      if (off >= 33554432) off -= 67108864;
    end else begin
      off = longint'(inst[25:10]);
      if (off >= 32768) off -= 65536;
    end
    return off * 4;
  endfunction

  function automatic bit ref_taken(input logic [31:0] inst);
    int op = int'(inst[31:26]);
    if (op == 20 || op == 21) return 1'b1;
    if (op >= 22 && op <= 27) begin
`ifdef PREDECODE_BTFN_EN
      return ref_offset(inst) < 0;
`else
      return 1'b0;
`endif
    end
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_target(input logic [31:0] pc, input logic [31:0] inst);
    longint t = longint'(pc) + ref_offset(inst);
    return t[31:0];
  endfunction

  function automatic logic [W-1:0] ref_bus(input logic [74:0] fb);
    logic [31:0] pc   = fb[74:43];
    logic [31:0] inst = fb[42:11];
    bit t = !fb[9] && ref_taken(inst);
    return {pc, inst, t, t ? ref_target(pc, inst) : 32'h0, fb[9], fb[8:1], fb[0]};
  endfunction

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ex;
    bit          evald;
  } m_ent_t;

  m_ent_t mq[$];                 // model occupancy, oldest first
  logic [W-1:0] exp_q[$];        // scoreboard of expected Decode outputs
  bit m_flush, m_pop, m_eval, m_pred, m_push, m_allow, m_rdy;

  // Predict what the DUT shows this cycle and what happens at the next edge.
  always @(negedge clk) begin
    if (!rstn) begin
      m_flush = 0; m_pop = 0; m_eval = 0; m_pred = 0; m_push = 0;
    end else begin
      m_flush = br_taken_D | br_taken_E | ex_en | ertn_flush;
      m_rdy   = mq.size() > 0 && mq[0].evald && !m_flush;
      m_pop   = m_rdy && D_allowin;
      m_eval  = mq.size() > 0 && !mq[0].evald && !m_flush;
      m_pred  = m_eval && !mq[0].ex && ref_taken(mq[0].inst);
      m_allow = mq.size() < DEPTH || (mq.size() == DEPTH && m_pop);
      m_push  = FpD_valid && m_allow && !m_flush;
      chk("allowin", pD_allowin, m_allow);
      chk("pdd_valid", pDD_valid, m_rdy);
      chk("predict_bus", predict_BUS,
          m_pred ? {1'b1, ref_target(mq[0].pc, mq[0].inst)} : 33'h0);
    end
  end

  always @(posedge clk) begin
    if (!rstn) begin
      mq.delete();
      exp_q.delete();
    end else if (m_flush) begin
      mq.delete();
      exp_q.delete();
    end else begin
      if (m_pop) void'(mq.pop_front());
      if (m_pred) begin
        mq[0].evald = 1;
        while (mq.size() > 1) void'(mq.pop_back());
        while (exp_q.size() > 1) void'(exp_q.pop_back());
      end else if (m_eval) begin
        mq[0].evald = 1;
      end
      if (m_push) begin
        mq.push_back('{pc: FpD_BUS[74:43], inst: FpD_BUS[42:11], ex: FpD_BUS[9], evald: 0});
        exp_q.push_back(ref_bus(FpD_BUS));
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rstn && pDD_valid && D_allowin) begin
      if (exp_q.size() == 0) chk("unexpected_output", pDD_BUS, 107'h0 - 1);
      else chk("pdd_bus", pDD_BUS, exp_q.pop_front());
    end
  end

  // ---------------- driver ----------------
  task automatic cyc(input logic fv, input logic [31:0] pc, input logic [31:0] inst,
                     input logic ex, input logic dal, input logic [3:0] fl);
    @(posedge clk); #1;
    FpD_valid = fv;
    FpD_BUS   = {pc, inst, 1'b1, ex, ex ? 8'($urandom) : 8'h0, ex ? 1'($urandom) : 1'b0};
    D_allowin = dal;
    {br_taken_D, br_taken_E, ex_en, ertn_flush} = fl;
    #1;
    // Fetch holds off while it is being redirected.
    if (predict_BUS[32]) FpD_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, NOP, 1'b0, 1'b1, 4'h0);
  endtask

  function automatic logic [31:0] rand_inst();
    case ($urandom_range(0, 6))
      0:       return {6'b010100, 26'($urandom)};
      1:       return {6'b010101, 26'($urandom)};
      2, 3:    return {6'($urandom_range(22, 27)), 26'($urandom)};
      4:       return {6'b010011, 26'($urandom)};
      5:       return NOP;
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    rstn = 1'b0; FpD_valid = 1'b0; FpD_BUS = '0; D_allowin = 1'b0;
    br_taken_D = 0; br_taken_E = 0; ex_en = 0; ertn_flush = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_allowin", pD_allowin, 1'b1);
    chk("rst_pdd_valid", pDD_valid, 1'b0);
    chk("rst_predict", predict_BUS, 33'h0);
    chk("rst_pdd_bus", pDD_BUS, 107'h0);
    @(posedge clk); #1 rstn = 1'b1;

    // nop: offered to Decode two cycles after the push cycle, not predicted
    cyc(1'b1, 32'h1c000000, NOP, 1'b0, 1'b1, 4'h0);
    cyc(1'b0, 32'h0, NOP, 1'b0, 1'b1, 4'h0);
    chk("nop_eval_cycle", pDD_valid, 1'b0);
    cyc(1'b0, 32'h0, NOP, 1'b0, 1'b1, 4'h0);
    chk("nop_valid", pDD_valid, 1'b1);
    chk("nop_pred", pDD_BUS[42], 1'b0);
    idle(2);

    // B: one-cycle redirect to 0x1c000040
    cyc(1'b1, 32'h1c000000, BINS, 1'b0, 1'b1, 4'h0);
    cyc(1'b0, 32'h0, NOP, 1'b0, 1'b1, 4'h0);
    chk("b_predict", predict_BUS, 33'h1_1c000040);
    cyc(1'b0, 32'h0, NOP, 1'b0, 1'b1, 4'h0);
    chk("b_once", predict_BUS[32], 1'b0);
    chk("b_target", pDD_BUS[42:10], {1'b1, 32'h1c000040});
    idle(2);

    // fill, then pop+push while full
    cyc(1'b1, 32'h1c000010, NOP, 1'b0, 1'b0, 4'h0);
    cyc(1'b1, 32'h1c000014, NOP, 1'b0, 1'b0, 4'h0);
    cyc(1'b0, 32'h0, NOP, 1'b0, 1'b0, 4'h0);
    chk("full_allowin", pD_allowin, 1'b0);
    cyc(1'b1, 32'h1c000018, NOP, 1'b0, 1'b1, 4'h0);
    chk("full_pop_allowin", pD_allowin, 1'b1);
    idle(5);

    // B at head with a younger entry behind it: the younger one is dropped
    cyc(1'b1, 32'h1c000200, NOP, 1'b0, 1'b0, 4'h0);
    cyc(1'b1, 32'h1c000204, BINS, 1'b0, 1'b0, 4'h0);
    cyc(1'b0, 32'h0, NOP, 1'b0, 1'b0, 4'h0);
    cyc(1'b1, 32'h1c000208, NOP, 1'b0, 1'b1, 4'h0);
    cyc(1'b0, 32'h0, NOP, 1'b0, 1'b1, 4'h0);
    chk("drop_predict", predict_BUS, 33'h1_1c000244);
    cyc(1'b1, 32'h1c000244, NOP, 1'b0, 1'b1, 4'h0);
    idle(4);

    // backward BEQ
    cyc(1'b1, 32'h1c000100, BEQI, 1'b0, 1'b1, 4'h0);
    cyc(1'b0, 32'h0, NOP, 1'b0, 1'b1, 4'h0);
`ifdef PREDECODE_BTFN_EN
    chk("beq_predict", predict_BUS, 33'h1_1c0000f0);
`else
    chk("beq_predict", predict_BUS, 33'h0);
`endif
    idle(3);

    // full queue then ex_en flush; the push in the flush cycle is lost
    cyc(1'b1, 32'h1c000300, NOP, 1'b0, 1'b0, 4'h0);
    cyc(1'b1, 32'h1c000304, BINS, 1'b0, 1'b0, 4'h0);
    cyc(1'b0, 32'h0, NOP, 1'b0, 1'b0, 4'h0);
    cyc(1'b1, 32'h1c000308, NOP, 1'b0, 1'b0, 4'b0010);
    chk("flush_cycle_valid", pDD_valid, 1'b0);
    chk("flush_cycle_predict", predict_BUS, 33'h0);
    cyc(1'b0, 32'h0, NOP, 1'b0, 1'b0, 4'h0);
    chk("post_flush_valid", pDD_valid, 1'b0);
    chk("post_flush_allowin", pD_allowin, 1'b1);
    idle(3);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] pc;
      logic [3:0]  fl;
      pc = ($urandom_range(0, 9) == 0) ? (32'($urandom) & 32'hffff_fffc)
                                       : 32'h1c000000 + 32'($urandom_range(0, 4095)) * 4;
      fl = ($urandom_range(0, 99) < 4) ? 4'(1 << $urandom_range(0, 3)) : 4'h0;
      cyc($urandom_range(0, 99) < 70, pc, rand_inst(), $urandom_range(0, 9) == 0,
          $urandom_range(0, 99) < 75, fl);
    end

    idle(10);
    chk("drain_exp_q", exp_q.size(), 0);
    chk("drain_model", mq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
